// File: rtl/ram8x16k_bank.sv
// ram8x16k_bank
//   One byte lane of the LSU data memory: 16384 x 8 single-port RAM with a
//   synchronous write and a combinational read. The storage array is named
//   data_mem so the LSU can preload it hierarchically at time zero; the
//   INIT_FILE parameter carries the name of that file down to this level.
//
//   Optional feature macro: RAM8X16K_CLEAR_ON_RESET_EN
//     defined   : every reset starts a sweep that zeroes the whole array,
//                 one location per clock; busy_o is high while it runs and
//                 writes are dropped and reads return 0 during the sweep.
//     undefined : reset only blocks writes, busy_o is tied low, the array
//                 stays a plain RAM.
//
// Ports
//   clk_i    in   1       clock, rising edge
//   rst_i    in   1       synchronous active-high reset
//   wren_i   in   1       write enable
//   addr_i   in   ADDR_W  word address shared by read and write
//   wdata_i  in   DATA_W  write data
//   rdata_o  out  DATA_W  combinational read data
//   busy_o   out  1       clear sweep in progress

module ram8x16k_bank #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter     INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wren_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] data_mem [0:2**ADDR_W-1];

`ifdef RAM8X16K_CLEAR_ON_RESET_EN

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            // last index cleared on this edge ends the sweep
            if (cnt_q == {ADDR_W{1'b1}}) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Sweep owns the write port while busy; user writes are dropped, not queued.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (busy_q) begin
                data_mem[cnt_q] <= '0;
            end else if (wren_i) begin
                data_mem[addr_i] <= wdata_i;
            end
        end
    end

    assign busy_o  = busy_q;
    assign rdata_o = busy_q ? '0 : data_mem[addr_i];

`else

    always_ff @(posedge clk_i) begin
        if (wren_i && !rst_i) begin
            data_mem[addr_i] <= wdata_i;
        end
    end

    assign busy_o  = 1'b0;
    assign rdata_o = data_mem[addr_i];

`endif

endmodule

// File: tb/tb_ram8x16k_bank.sv
module tb_ram8x16k_bank;

    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wren_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic          busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the memory as a plain byte array, updated by the write rule.
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    ram8x16k_bank #(.ADDR_W(AW), .DATA_W(DW), .INIT_FILE("")) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wren_i (wren_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .rdata_o(rdata_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge, land 1 time unit after it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_ref_edge();
        tick();
        if (wren_i && !rst_i) ref_mem[addr_i] = wdata_i;
    endtask

    task automatic random_traffic(input int cycles, input bit allow_rst);
        for (int i = 0; i < cycles; i++) begin
            addr_i  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            wren_i  = $urandom_range(0, 1) == 1;
            wdata_i = DW'($urandom);
            rst_i   = allow_rst && ($urandom_range(0, 15) == 0);
            #1;
            check("rand_read", 16'(rdata_o), 16'(ref_mem[addr_i]));
            write_ref_edge();
        end
        rst_i  = 1'b0;
        wren_i = 1'b0;
    endtask

`ifdef RAM8X16K_CLEAR_ON_RESET_EN
    // Returns number of edges after release until busy_o falls.
    task automatic count_busy(output int n, input int write_at);
        n = 0;
        while (busy_o && n < 20000) begin
            if (n == write_at) begin
                addr_i = 14'h0055; wdata_i = 8'h77; wren_i = 1'b1;
                #1;
                check("busy_read_zero", 16'(rdata_o), 16'h0000);
            end else begin
                wren_i = 1'b0;
            end
            tick();
            n++;
        end
        wren_i = 1'b0;
    endtask
`endif

    initial begin
        int n;
        rst_i = 1'b0; wren_i = 1'b0; addr_i = '0; wdata_i = '0;

`ifdef RAM8X16K_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) begin
            dut.data_mem[i] = 8'h5A;
            ref_mem[i]      = 8'h00;
        end
        rst_i = 1'b1;
        tick(); tick();
        check("rst_busy", 16'(busy_o), 16'h0001);
        check("rst_rdata", 16'(rdata_o), 16'h0000);
        rst_i = 1'b0;
        count_busy(n, 100);
        check("busy_len", 16'(n), 16'(DEPTH));
        check("busy_low", 16'(busy_o), 16'h0000);
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            addr_i = AW'(i);
            #1;
            if (rdata_o !== 8'h00) n++;
        end
        check("swept_nonzero_cnt", 16'(n), 16'h0000);
        addr_i = 14'h0055; #1;
        check("dropped_write", 16'(rdata_o), 16'h0000);

        // reset in mid-sweep restarts from index 0
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        for (int i = 0; i < 8000; i++) tick();
        check("mid_busy", 16'(busy_o), 16'h0001);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        count_busy(n, -1);
        check("restart_len", 16'(n), 16'(DEPTH));

        random_traffic(1500, 1'b0);
`else
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]      = DW'($urandom);
        end
        ref_mem[14'h0010] = 8'hA5;
        ref_mem[14'h0042] = 8'h00;
        ref_mem[14'h0100] = 8'h11;
        for (int i = 0; i < DEPTH; i++) dut.data_mem[i] = ref_mem[i];

        // writes attempted during reset are blocked
        rst_i = 1'b1; wren_i = 1'b1; addr_i = 14'h0042; wdata_i = 8'hFF;
        tick(); tick();
        check("rst_busy", 16'(busy_o), 16'h0000);
        rst_i = 1'b0; wren_i = 1'b0;
        addr_i = 14'h0010; #1;
        check("preload_read", 16'(rdata_o), 16'h00A5);
        addr_i = 14'h0042; #1;
        check("rst_write_blocked", 16'(rdata_o), 16'h0000);

        addr_i = 14'h3FFF; wdata_i = 8'h3C; wren_i = 1'b1;
        write_ref_edge();
        wren_i = 1'b0; #1;
        check("top_addr", 16'(rdata_o), 16'h003C);
        addr_i = 14'h0000; #1;
        check("addr0_unchanged", 16'(rdata_o), 16'(ref_mem[0]));

        addr_i = 14'h0100; wdata_i = 8'h22; wren_i = 1'b1; #1;
        check("rw_before", 16'(rdata_o), 16'h0011);
        write_ref_edge();
        wren_i = 1'b0;
        check("rw_after", 16'(rdata_o), 16'h0022);

        random_traffic(2000, 1'b1);
        check("busy_end", 16'(busy_o), 16'h0000);
`endif

        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            addr_i = AW'(i);
            #1;
            if (rdata_o !== ref_mem[i]) n++;
        end
        check("final_scan_diff_cnt", 16'(n), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
